// File: rtl/vga_glyph_fetch_if.sv
// Bus bundle for the glyph fetcher: the memory-controller side (arbiter
// count, shared read data, address into the mux) and the text-row side
// (start/row parameters, FIFO pop port and status).
interface vga_glyph_fetch_if;
  // memory-controller side
  logic [2:0]  acnt;
  logic [15:0] dmem;
  logic [15:0] glyph_addr;
  // row request
  logic        start;
  logic [15:0] row_base;
  logic [3:0]  glyph_row;
  logic [6:0]  num_cells;
  // FIFO consumer and status
  logic        rd_en;
  logic [15:0] rd_data;
  logic        empty;
  logic        busy;
  logic        done;
  logic        underrun;

  // The fetcher itself
  modport slave (
    input  acnt, dmem, start, row_base, glyph_row, num_cells, rd_en,
    output glyph_addr, rd_data, empty, busy, done, underrun
  );

  // Whoever drives requests, pops rows and supplies memory data
  modport master (
    output acnt, dmem, start, row_base, glyph_row, num_cells, rd_en,
    input  glyph_addr, rd_data, empty, busy, done, underrun
  );
endinterface

// File: rtl/vga_glyph_fetch.sv
// Display-side memory client: in the VGA-owned arbiter slots it reads a tile
// index from the framebuffer, then the matching glyph row from ROM, and
// queues the 16-bit row in a small FIFO for the pixel serializer.
module vga_glyph_fetch #(
  parameter logic [2:0]  TILE_SLOT  = 3'd1,
  parameter logic [2:0]  GLYPH_SLOT = 3'd5,
  parameter logic [15:0] GLYPH_BASE = 16'h4000,
  parameter int          DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst,
  vga_glyph_fetch_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_TILE, WAIT_GLYPH} state_t;

  state_t            state_q, state_d;
  logic [15:0]       row_base_q, row_base_d;
  logic [3:0]        glyph_row_q, glyph_row_d;
  logic [6:0]        num_cells_q, num_cells_d;
  logic [6:0]        cell_idx_q, cell_idx_d;
  logic [15:0]       glyph_addr_q, glyph_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       mem_q [DEPTH];

  logic              push;
  logic              pop;
  logic              flush;
  logic              fifo_empty;
  logic [6:0]        cell_idx_inc;
  logic [DEPTH-1:0]  wr_sel;

  assign fifo_empty   = (count_q == '0);
  assign cell_idx_inc = cell_idx_q + 7'd1;

  // Next-state, request latching and slot handling; start overrides any
  // in-flight work so an aborted row leaves nothing behind.
  always_comb begin
    state_d      = state_q;
    row_base_d   = row_base_q;
    glyph_row_d  = glyph_row_q;
    num_cells_d  = num_cells_q;
    cell_idx_d   = cell_idx_q;
    glyph_addr_d = glyph_addr_q;
    done_d       = 1'b0;
    push         = 1'b0;
    flush        = 1'b0;

    if (bus.start) begin
      flush       = 1'b1;
      row_base_d  = bus.row_base;
      glyph_row_d = bus.glyph_row;
      num_cells_d = bus.num_cells;
      cell_idx_d  = 7'd0;
      if (bus.num_cells == 7'd0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d      = WAIT_TILE;
        glyph_addr_d = bus.row_base;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        WAIT_TILE: begin
          // Only claim a tile when its glyph row is sure to fit; otherwise
          // the slot is skipped and retried on the next arbiter lap.
          if ((bus.acnt == TILE_SLOT) && (count_q < DEPTH_C)) begin
            glyph_addr_d = GLYPH_BASE + {4'b0000, bus.dmem[7:0], glyph_row_q};
            state_d      = WAIT_GLYPH;
          end
        end
        WAIT_GLYPH: begin
          if (bus.acnt == GLYPH_SLOT) begin
            push       = 1'b1;
            cell_idx_d = cell_idx_inc;
            if (cell_idx_inc == num_cells_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d      = WAIT_TILE;
              glyph_addr_d = row_base_q + {9'd0, cell_idx_inc};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status flags: busy follows the next state; underrun is sticky until start.
  always_comb begin
    busy_d     = (state_d != IDLE);
    underrun_d = underrun_q;
    if (bus.start) begin
      underrun_d = 1'b0;
    end else if (bus.rd_en && fifo_empty) begin
      underrun_d = 1'b1;
    end
  end

  // FIFO pointers and occupancy; a flush beats any concurrent pop.
  assign pop = bus.rd_en && !fifo_empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // One write strobe per FIFO entry, decoded from the write pointer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = push && (wr_ptr_q == PTR_W'(gi));
    end
  endgenerate

  // FIFO storage; contents need no reset because occupancy gates the output.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) begin
        mem_q[i] <= bus.dmem;
      end
    end
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      row_base_q   <= '0;
      glyph_row_q  <= '0;
      num_cells_q  <= '0;
      cell_idx_q   <= '0;
      glyph_addr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      row_base_q   <= row_base_d;
      glyph_row_q  <= glyph_row_d;
      num_cells_q  <= num_cells_d;
      cell_idx_q   <= cell_idx_d;
      glyph_addr_q <= glyph_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign bus.glyph_addr = glyph_addr_q;
  assign bus.rd_data    = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];
  assign bus.empty      = fifo_empty;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_vga_glyph_fetch.sv
// Directed bench for vga_glyph_fetch: free-running arbiter count, a simple
// memory model answering glyph_addr, and one task per scenario.
module tb_vga_glyph_fetch;

  logic clk;
  logic rst;
  logic [2:0] acnt_r = 3'd0;
  int checks = 0;
  int failures = 0;

  vga_glyph_fetch_if bus();

  vga_glyph_fetch #(
    .TILE_SLOT (3'd1),
    .GLYPH_SLOT(3'd5),
    .GLYPH_BASE(16'h4000),
    .DEPTH     (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbiter count free-runs like the CPU's.
  always @(posedge clk) acnt_r <= acnt_r + 3'd1;
  assign bus.acnt = acnt_r;

  // Memory model: two fixed words, framebuffer tiles = low byte + 0x10 with
  // junk in the high byte, ROM words = inverted address.
  function automatic logic [15:0] dmem_model(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0] + 8'h10;
    if (a == 16'h0100) return 16'h0041;
    if (a == 16'h4413) return 16'hA55A;
    if (a < 16'h4000) return {8'hEE, lo};
    return ~a;
  endfunction

  function automatic logic [15:0] rom_addr(input logic [15:0] base, input int idx, input logic [3:0] g);
    logic [15:0] w;
    logic [7:0]  t;
    w = dmem_model(base + 16'(idx));
    t = w[7:0];
    return 16'h4000 + {4'h0, t, g};
  endfunction

  function automatic logic [15:0] exp_row(input logic [15:0] base, input int idx, input logic [3:0] g);
    return dmem_model(rom_addr(base, idx, g));
  endfunction

  assign bus.dmem = dmem_model(bus.glyph_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acnt(input logic [2:0] k);
    int n;
    n = 0;
    while (bus.acnt !== k && n < 16) begin
      tick();
      n++;
    end
    checks++;
    if (bus.acnt !== k) begin failures++; $display("FAIL wait_acnt got=%0d exp=%0d", bus.acnt, k); end
  endtask

  task automatic pulse_start(input logic [15:0] base, input logic [3:0] g, input logic [6:0] n);
    bus.row_base  = base;
    bus.glyph_row = g;
    bus.num_cells = n;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", bus.underrun); end
    checks++; if (bus.glyph_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", bus.glyph_addr); end
    checks++; if (bus.rd_data !== 16'h0000) begin failures++; $display("FAIL reset_rd_data got=%h exp=0000", bus.rd_data); end
    rst = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single_cell();
    wait_acnt(3'd6);
    pulse_start(16'h0100, 4'd3, 7'd1);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    wait_acnt(3'd1);
    checks++; if (bus.glyph_addr !== 16'h0100) begin failures++; $display("FAIL single_tile_addr got=%h exp=0100", bus.glyph_addr); end
    wait_acnt(3'd5);
    checks++; if (bus.glyph_addr !== 16'h4413) begin failures++; $display("FAIL single_glyph_addr got=%h exp=4413", bus.glyph_addr); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL single_empty_before got=%b exp=1", bus.empty); end
    tick();
    checks++; if (bus.rd_data !== 16'hA55A) begin failures++; $display("FAIL single_rd_data got=%h exp=a55a", bus.rd_data); end
    checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL single_empty_after got=%b exp=0", bus.empty); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%b exp=0", bus.busy); end
    tick();
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL single_done_once got=%b exp=0", bus.done); end
    pop_one();
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL single_drained got=%b exp=1", bus.empty); end
    $display("test_single_cell done");
  endtask

  task automatic test_push_pop_count1();
    wait_acnt(3'd6);
    pulse_start(16'h0300, 4'd2, 7'd2);
    wait_acnt(3'd6);
    checks++; if (bus.rd_data !== 16'hBEFD) begin failures++; $display("FAIL pp_first got=%h exp=befd", bus.rd_data); end
    tick();
    wait_acnt(3'd5);
    checks++; if (bus.rd_data !== 16'hBEFD) begin failures++; $display("FAIL pp_head_hold got=%h exp=befd", bus.rd_data); end
    pop_one();
    checks++; if (bus.rd_data !== 16'hBEED) begin failures++; $display("FAIL pp_new_head got=%h exp=beed", bus.rd_data); end
    checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL pp_not_empty got=%b exp=0", bus.empty); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL pp_done got=%b exp=1", bus.done); end
    pop_one();
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL pp_count_one got=%b exp=1", bus.empty); end
    $display("test_push_pop_count1 done");
  endtask

  task automatic test_full_stall();
    wait_acnt(3'd6);
    pulse_start(16'h0500, 4'd7, 7'd6);
    for (int f = 0; f < 4; f++) begin
      wait_acnt(3'd5);
      checks++; if (bus.glyph_addr !== rom_addr(16'h0500, f, 4'd7)) begin failures++; $display("FAIL stall_fill%0d got=%h exp=%h", f, bus.glyph_addr, rom_addr(16'h0500, f, 4'd7)); end
      tick();
    end
    for (int f = 0; f < 2; f++) begin
      wait_acnt(3'd5);
      checks++; if (bus.glyph_addr !== 16'h0504) begin failures++; $display("FAIL stall_hold%0d got=%h exp=0504", f, bus.glyph_addr); end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL stall_busy%0d got=%b exp=1", f, bus.busy); end
      tick();
    end
    checks++; if (bus.rd_data !== exp_row(16'h0500, 0, 4'd7)) begin failures++; $display("FAIL stall_head0 got=%h exp=%h", bus.rd_data, exp_row(16'h0500, 0, 4'd7)); end
    pop_one();
    wait_acnt(3'd5);
    checks++; if (bus.glyph_addr !== rom_addr(16'h0500, 4, 4'd7)) begin failures++; $display("FAIL stall_cell4 got=%h exp=%h", bus.glyph_addr, rom_addr(16'h0500, 4, 4'd7)); end
    tick();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL stall_busy_after4 got=%b exp=1", bus.busy); end
    checks++; if (bus.rd_data !== exp_row(16'h0500, 1, 4'd7)) begin failures++; $display("FAIL stall_head1 got=%h exp=%h", bus.rd_data, exp_row(16'h0500, 1, 4'd7)); end
    pop_one();
    wait_acnt(3'd5);
    checks++; if (bus.glyph_addr !== rom_addr(16'h0500, 5, 4'd7)) begin failures++; $display("FAIL stall_cell5 got=%h exp=%h", bus.glyph_addr, rom_addr(16'h0500, 5, 4'd7)); end
    tick();
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", bus.done); end
    for (int k = 2; k < 6; k++) begin
      checks++; if (bus.rd_data !== exp_row(16'h0500, k, 4'd7)) begin failures++; $display("FAIL stall_drain%0d got=%h exp=%h", k, bus.rd_data, exp_row(16'h0500, k, 4'd7)); end
      pop_one();
    end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL stall_empty got=%b exp=1", bus.empty); end
    $display("test_full_stall done");
  endtask

  task automatic test_underrun();
    wait_acnt(3'd6);
    pulse_start(16'h0100, 4'd3, 7'd1);
    pop_one();
    checks++; if (bus.underrun !== 1'b1) begin failures++; $display("FAIL ur_set got=%b exp=1", bus.underrun); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL ur_empty got=%b exp=1", bus.empty); end
    wait_acnt(3'd6);
    checks++; if (bus.rd_data !== 16'hA55A) begin failures++; $display("FAIL ur_ptr_kept got=%h exp=a55a", bus.rd_data); end
    checks++; if (bus.underrun !== 1'b1) begin failures++; $display("FAIL ur_sticky got=%b exp=1", bus.underrun); end
    pop_one();
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL ur_single_entry got=%b exp=1", bus.empty); end
    bus.rd_en = 1'b1;
    pulse_start(16'h0000, 4'd0, 7'd0);
    bus.rd_en = 1'b0;
    checks++; if (bus.underrun !== 1'b0) begin failures++; $display("FAIL ur_cleared got=%b exp=0", bus.underrun); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL ur_zero_done got=%b exp=1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ur_zero_busy got=%b exp=0", bus.busy); end
    tick();
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL ur_zero_done_once got=%b exp=0", bus.done); end
    $display("test_underrun done");
  endtask

  task automatic test_abort();
    logic exp_done;
    wait_acnt(3'd6);
    pulse_start(16'h0600, 4'd1, 7'd10);
    wait_acnt(3'd6);
    checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL ab_first_push got=%b exp=0", bus.empty); end
    wait_acnt(3'd3);
    pulse_start(16'h0200, 4'd1, 7'd3);
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL ab_flush got=%b exp=1", bus.empty); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL ab_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL ab_no_done got=%b exp=0", bus.done); end
    wait_acnt(3'd5);
    checks++; if (bus.glyph_addr !== 16'h0200) begin failures++; $display("FAIL ab_discard_addr got=%h exp=0200", bus.glyph_addr); end
    tick();
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL ab_discard_push got=%b exp=1", bus.empty); end
    for (int f = 0; f < 3; f++) begin
      wait_acnt(3'd1);
      checks++; if (bus.glyph_addr !== 16'h0200 + 16'(f)) begin failures++; $display("FAIL ab_tile%0d got=%h exp=%h", f, bus.glyph_addr, 16'h0200 + 16'(f)); end
      wait_acnt(3'd5);
      checks++; if (bus.glyph_addr !== rom_addr(16'h0200, f, 4'd1)) begin failures++; $display("FAIL ab_glyph%0d got=%h exp=%h", f, bus.glyph_addr, rom_addr(16'h0200, f, 4'd1)); end
      tick();
      exp_done = (f == 2);
      checks++; if (bus.done !== exp_done) begin failures++; $display("FAIL ab_done%0d got=%b exp=%b", f, bus.done, exp_done); end
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.rd_data !== exp_row(16'h0200, k, 4'd1)) begin failures++; $display("FAIL ab_drain%0d got=%h exp=%h", k, bus.rd_data, exp_row(16'h0200, k, 4'd1)); end
      pop_one();
    end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL ab_exact3 got=%b exp=1", bus.empty); end
    $display("test_abort done");
  endtask

  task automatic test_reset_mid_fetch();
    wait_acnt(3'd6);
    pulse_start(16'h0700, 4'd5, 7'd4);
    wait_acnt(3'd6);
    tick();
    wait_acnt(3'd6);
    checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL rm_queued got=%b exp=0", bus.empty); end
    wait_acnt(3'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL rm_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.glyph_addr !== 16'h0000) begin failures++; $display("FAIL rm_addr got=%h exp=0000", bus.glyph_addr); end
    checks++; if (bus.underrun !== 1'b0) begin failures++; $display("FAIL rm_underrun got=%b exp=0", bus.underrun); end
    wait_acnt(3'd6);
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL rm_no_push got=%b exp=1", bus.empty); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rm_no_done got=%b exp=0", bus.done); end
    $display("test_reset_mid_fetch done");
  endtask

  initial begin
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.rd_en     = 1'b0;
    bus.row_base  = 16'h0000;
    bus.glyph_row = 4'd0;
    bus.num_cells = 7'd0;
    test_reset();
    test_single_cell();
    test_push_pop_count1();
    test_full_stall();
    test_underrun();
    test_abort();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
